// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational picoMIPS ALU between the core
// datapath (port 0) and the transform/debug engine (port 1).
module alu_arbiter #(
   parameter int N      = 8,
   parameter int FUNC_W = 2
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic [N-1:0]      p0_a,
   input  logic [N-1:0]      p0_b,
   input  logic [FUNC_W-1:0] p0_func,
   output logic              p0_resp_valid,
   input  logic              p0_resp_ready,
   output logic [N-1:0]      p0_result,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic [N-1:0]      p1_a,
   input  logic [N-1:0]      p1_b,
   input  logic [FUNC_W-1:0] p1_func,
   output logic              p1_resp_valid,
   input  logic              p1_resp_ready,
   output logic [N-1:0]      p1_result,
   output logic [N-1:0]      alu_a,
   output logic [N-1:0]      alu_b,
   output logic [FUNC_W-1:0] alu_func,
   input  logic [N-1:0]      alu_result,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [N-1:0]        a_reg;
   logic [N-1:0]        b_reg;
   logic [FUNC_W-1:0]   func_reg;
   logic                owner;
   logic                ptr;
   logic [N-1:0]        res0;
   logic [N-1:0]        res1;
   logic                grant0;
   logic                grant1;
   logic                owner_resp_ready;

   assign owner_resp_ready = owner ? p1_resp_ready : p0_resp_ready;

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grants are only evaluated in IDLE; ptr names the port that wins a tie.
   always_comb begin
      grant0     = 1'b0;
      grant1     = 1'b0;
      state_next = state;
      case (state)
         IDLE: begin
            grant0 = p0_valid && (!p1_valid || !ptr);
            grant1 = p1_valid && (!p0_valid ||  ptr);
            if (grant0 || grant1) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            if (owner_resp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         a_reg    <= '0;
         b_reg    <= '0;
         func_reg <= '0;
         owner    <= 1'b0;
         ptr      <= 1'b0;
         res0     <= '0;
         res1     <= '0;
      end else begin
         if (grant0) begin
            a_reg    <= p0_a;
            b_reg    <= p0_b;
            func_reg <= p0_func;
            owner    <= 1'b0;
            ptr      <= 1'b1;
         end else if (grant1) begin
            a_reg    <= p1_a;
            b_reg    <= p1_b;
            func_reg <= p1_func;
            owner    <= 1'b1;
            ptr      <= 1'b0;
         end
         if (state == EXEC) begin
            if (owner) begin
               res1 <= alu_result;
            end else begin
               res0 <= alu_result;
            end
         end
      end
   end

   assign p0_ready      = grant0;
   assign p1_ready      = grant1;
   assign p0_resp_valid = (state == RESP) && !owner;
   assign p1_resp_valid = (state == RESP) &&  owner;
   assign p0_result     = res0;
   assign p1_result     = res1;
   assign alu_a         = a_reg;
   assign alu_b         = b_reg;
   assign alu_func      = func_reg;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level reference checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_alu_arbiter;

   localparam int N  = 8;
   localparam int FW = 2;
   localparam logic [1:0] F_RB     = 2'd0;
   localparam logic [1:0] F_RB_ALT = 2'd1;
   localparam logic [1:0] F_RADD   = 2'd2;
   localparam logic [1:0] F_RMULT  = 2'd3;

   logic          clk = 1'b0;
   logic          n_reset;
   logic          p0_valid, p0_ready, p0_resp_valid, p0_resp_ready;
   logic [N-1:0]  p0_a, p0_b, p0_result;
   logic [FW-1:0] p0_func;
   logic          p1_valid, p1_ready, p1_resp_valid, p1_resp_ready;
   logic [N-1:0]  p1_a, p1_b, p1_result;
   logic [FW-1:0] p1_func;
   logic [N-1:0]  alu_a, alu_b, alu_result;
   logic [FW-1:0] alu_func;
   logic          busy;

   int errors = 0;
   int checks = 0;

   alu_arbiter #(.N(N), .FUNC_W(FW)) dut (
      .clk(clk), .n_reset(n_reset),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_a(p0_a), .p0_b(p0_b),
      .p0_func(p0_func), .p0_resp_valid(p0_resp_valid),
      .p0_resp_ready(p0_resp_ready), .p0_result(p0_result),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_a(p1_a), .p1_b(p1_b),
      .p1_func(p1_func), .p1_resp_valid(p1_resp_valid),
      .p1_resp_ready(p1_resp_ready), .p1_result(p1_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
      .alu_result(alu_result), .busy(busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the picoMIPS ALU: MULT keeps Q1.7 bits [14:7].
   function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] f);
      logic signed [15:0] p;
      p = $signed(a) * $signed(b);
      case (f)
         F_RADD:  return a + b;
         F_RMULT: return p[14:7];
         default: return b;
      endcase
   endfunction

   always_comb alu_result = aluRef(alu_a, alu_b, alu_func);

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                                input logic [1:0] f0, input logic v1, input logic [7:0] a1,
                                input logic [7:0] b1, input logic [1:0] f1,
                                input logic rr0, input logic rr1);
      p0_valid = v0; p0_a = a0; p0_b = b0; p0_func = f0;
      p1_valid = v1; p1_a = a1; p1_b = b1; p1_func = f1;
      p0_resp_ready = rr0;
      p1_resp_ready = rr1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      n_reset = 1'b0;
      tick();
      n_reset = 1'b1;
   endtask

   // Reference: one transaction in flight; age 1 = operating, age >= 2 = responding.
   bit          m_known = 1'b0;
   bit          m_active, m_owner, m_ptr;
   int          m_age;
   logic [7:0]  m_a, m_b, m_pending;
   logic [1:0]  m_f;
   logic [7:0]  m_res [2];

   always @(negedge clk) begin
      bit e_r0, e_r1, w;
      e_r0 = !m_active && p0_valid && (!p1_valid || !m_ptr);
      e_r1 = !m_active && p1_valid && (!p0_valid ||  m_ptr);
      if (m_known) begin
         checkOutput("cyc p0_ready", p0_ready, e_r0);
         checkOutput("cyc p1_ready", p1_ready, e_r1);
         checkOutput("cyc p0_resp_valid", p0_resp_valid, m_active && m_age >= 2 && !m_owner);
         checkOutput("cyc p1_resp_valid", p1_resp_valid, m_active && m_age >= 2 && m_owner);
         checkOutput("cyc p0_result", p0_result, m_res[0]);
         checkOutput("cyc p1_result", p1_result, m_res[1]);
         checkOutput("cyc busy", busy, m_active);
         checkOutput("cyc alu_a", alu_a, m_a);
         checkOutput("cyc alu_b", alu_b, m_b);
         checkOutput("cyc alu_func", alu_func, m_f);
      end
      if (!n_reset) begin
         m_known = 1'b1; m_active = 1'b0; m_owner = 1'b0; m_ptr = 1'b0; m_age = 0;
         m_a = '0; m_b = '0; m_f = '0; m_pending = '0; m_res[0] = '0; m_res[1] = '0;
      end else if (m_known) begin
         if (!m_active) begin
            if (e_r0 || e_r1) begin
               w = e_r1;
               m_a = w ? p1_a : p0_a;
               m_b = w ? p1_b : p0_b;
               m_f = w ? p1_func : p0_func;
               m_pending = aluRef(m_a, m_b, m_f);
               m_active = 1'b1; m_owner = w; m_age = 1; m_ptr = !w;
            end
         end else if (m_age == 1) begin
            m_res[m_owner] = m_pending;
            m_age = 2;
         end else if (m_owner ? p1_resp_ready : p0_resp_ready) begin
            m_active = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   int g [6];
   int exp_order [6] = '{0, 1, 0, 1, 0, 1};
   int n, cyc;

   initial begin
      n_reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_reset = 1'b0;
      tick();
      tick();
      #1;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset p0_resp_valid", p0_resp_valid, 0);
      checkOutput("reset p0_result", p0_result, 0);
      checkOutput("reset alu_a", alu_a, 0);
      checkOutput("reset alu_func", alu_func, 0);
      n_reset = 1'b1;

      $display("[TB] single request p0 RADD");
      applyStimulus(1, 8'h20, 8'h10, F_RADD, 0, 0, 0, 0, 1, 1);
      #1;
      checkOutput("t1 p0_ready", p0_ready, 1);
      checkOutput("t1 p1_ready", p1_ready, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      #1;
      checkOutput("t1 busy exec", busy, 1);
      checkOutput("t1 early resp", p0_resp_valid, 0);
      tick(); #1;
      checkOutput("t1 resp_valid", p0_resp_valid, 1);
      checkOutput("t1 result", p0_result, 8'h30);
      checkOutput("t1 busy resp", busy, 1);
      tick(); #1;
      checkOutput("t1 busy done", busy, 0);
      checkOutput("t1 resp cleared", p0_resp_valid, 0);

      $display("[TB] simultaneous requests");
      resetDut();
      applyStimulus(1, 8'h40, 8'h40, F_RMULT, 1, 8'h05, 8'h03, F_RADD, 1, 1);
      #1;
      checkOutput("t2 p0 wins", p0_ready, 1);
      checkOutput("t2 p1 waits", p1_ready, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 1, 8'h05, 8'h03, F_RADD, 1, 1);
      #1;
      checkOutput("t2 p1 held exec", p1_ready, 0);
      tick(); #1;
      checkOutput("t2 p0 resp", p0_resp_valid, 1);
      checkOutput("t2 p0 result", p0_result, 8'h20);
      checkOutput("t2 p1 held resp", p1_ready, 0);
      tick(); #1;
      checkOutput("t2 p1 granted", p1_ready, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      tick(); #1;
      checkOutput("t2 p1 resp", p1_resp_valid, 1);
      checkOutput("t2 p1 result", p1_result, 8'h08);
      tick();

      $display("[TB] continuous contention");
      applyStimulus(1, 8'h01, 8'h02, F_RB, 1, 8'h03, 8'h07, F_RB_ALT, 1, 1);
      #1;
      checkOutput("t3 ptr back to p0", p0_ready, 1);
      n = 0;
      cyc = 0;
      while (n < 6 && cyc < 40) begin
         if (p0_ready || p1_ready) begin
            g[n] = p1_ready ? 1 : 0;
            n++;
         end
         tick(); #1;
         cyc++;
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("t3 grant count", n, 6);
      for (int i = 0; i < 6; i++) begin
         if (i < n) checkOutput("t3 grant order", g[i], exp_order[i]);
      end
      tick();
      tick();

      $display("[TB] backpressure on p1");
      applyStimulus(0, 0, 0, 0, 1, 8'hC0, 8'h40, F_RMULT, 1, 0);
      #1;
      checkOutput("t4 lone p1 wins", p1_ready, 1);
      tick();
      applyStimulus(1, 8'h01, 8'h01, F_RADD, 0, 0, 0, 0, 1, 0);
      #1;
      checkOutput("t4 p0 blocked exec", p0_ready, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("t4 hold valid", p1_resp_valid, 1);
         checkOutput("t4 hold result", p1_result, 8'hE0);
         checkOutput("t4 p0 blocked", p0_ready, 0);
         tick();
      end
      applyStimulus(1, 8'h01, 8'h01, F_RADD, 0, 0, 0, 0, 1, 1);
      #1;
      checkOutput("t4 still valid", p1_resp_valid, 1);
      tick(); #1;
      checkOutput("t4 completed", p1_resp_valid, 0);
      checkOutput("t4 p0 now granted", p0_ready, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      tick();
      tick();

      $display("[TB] reset during operation");
      applyStimulus(1, 8'h11, 8'h22, F_RADD, 0, 0, 0, 0, 1, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      n_reset = 1'b0;
      #1;
      checkOutput("t5 busy in exec", busy, 1);
      tick();
      n_reset = 1'b1;
      #1;
      checkOutput("t5 idle", busy, 0);
      checkOutput("t5 no resp", p0_resp_valid, 0);
      checkOutput("t5 result cleared", p0_result, 0);
      checkOutput("t5 alu_a cleared", alu_a, 0);
      tick(); #1;
      checkOutput("t5 no late resp", p0_resp_valid, 0);
      applyStimulus(1, 8'h01, 8'h01, F_RADD, 1, 8'h01, 8'h01, F_RADD, 1, 1);
      #1;
      checkOutput("t5 ptr p0", p0_ready, 1);
      checkOutput("t5 ptr not p1", p1_ready, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("[TB] spurious pulses");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      checkOutput("t6 idle no resp", p0_resp_valid, 0);
      checkOutput("t6 idle busy", busy, 0);
      tick();
      applyStimulus(1, 8'h05, 8'h06, F_RB, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("t6 p0 granted", p0_ready, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 1, 8'h09, 8'h09, F_RADD, 0, 0);
      #1;
      checkOutput("t6 p1 refused", p1_ready, 0);
      checkOutput("t6 p0 resp", p0_resp_valid, 1);
      checkOutput("t6 p0 result", p0_result, 8'h06);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("t6 p1 still idle", p1_ready, 0);
      checkOutput("t6 p1 no resp", p1_resp_valid, 0);
      checkOutput("t6 busy held", busy, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick(); #1;
      checkOutput("t6 done", busy, 0);
      checkOutput("t6 p1 never served", p1_resp_valid, 0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
